// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master AXI4-Lite arbiter in front of a single-port SRAM.
//            Master 0 (IFU) issues reads only; master 1 (LSU) issues reads
//            and writes. One transaction is granted at a time and the grant
//            is held until its response handshake. Channels are forwarded
//            combinationally while granted. A watchdog closes any granted
//            transaction that stays open for TIMEOUT cycles and answers the
//            granted master with SLVERR.
// Ports    : clk, rst (synchronous, active-high)
//            m0_ar*/m0_r*           : IFU read channels
//            m1_ar*/m1_r*           : LSU read channels
//            m1_aw*/m1_w*/m1_b*     : LSU write channels
//            s_*                    : slave-side mirrors of the above
// Params   : TIMEOUT  cycles before the watchdog fires (>= 4)
// Macro    : ARB_RR_EN  defined   -> round-robin between m0 and m1
//                       undefined -> fixed priority m1 write > m1 read > m0
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  // IFU read
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  input  logic        m0_rready,
  // LSU read
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  input  logic        m1_rready,
  // LSU write
  input  logic        m1_awvalid,
  input  logic [31:0] m1_awaddr,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_awready,
  output logic        m1_wready,
  output logic        m1_bvalid,
  output logic [1:0]  m1_bresp,
  input  logic        m1_bready,
  // Slave side
  output logic        s_arvalid,
  output logic [31:0] s_araddr,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic [1:0]  s_rresp,
  output logic        s_rready,
  output logic        s_awvalid,
  output logic [31:0] s_awaddr,
  input  logic        s_awready,
  output logic        s_wvalid,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_wready,
  input  logic        s_bvalid,
  input  logic [1:0]  s_bresp,
  output logic        s_bready
);

  // Counter is at least 8 bits and at most 16 bits wide.
  localparam int c_CNT_W = ($clog2(TIMEOUT) < 8)  ? 8 :
                           ($clog2(TIMEOUT) > 16) ? 16 : $clog2(TIMEOUT);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD0  = 3'd1,
    S_RD1  = 3'd2,
    S_WR1  = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  state_t               r_owner;    // grant state that led into TOUT
  logic                 r_ar_done;
  logic                 r_aw_done;
  logic                 r_w_done;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 w_expire;
`ifdef ARB_RR_EN
  logic                 r_last;     // 1: m1 was served most recently
`endif

  assign w_expire = (r_cnt == c_CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    m0_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rdata    = '0;
    m0_rresp    = '0;
    m1_arready  = 1'b0;
    m1_rvalid   = 1'b0;
    m1_rdata    = '0;
    m1_rresp    = '0;
    m1_awready  = 1'b0;
    m1_wready   = 1'b0;
    m1_bvalid   = 1'b0;
    m1_bresp    = '0;
    s_arvalid   = 1'b0;
    s_araddr    = '0;
    s_rready    = 1'b0;
    s_awvalid   = 1'b0;
    s_awaddr    = '0;
    s_wvalid    = 1'b0;
    s_wdata     = '0;
    s_wstrb     = '0;
    s_bready    = 1'b0;

    case (r_state)
      S_IDLE: begin
`ifdef ARB_RR_EN
        // m1 wins unless m0 also requests and m1 was the last one served.
        if ((m1_awvalid || m1_arvalid) && (!m0_arvalid || !r_last))
          w_state_nxt = m1_awvalid ? S_WR1 : S_RD1;
        else if (m0_arvalid)
          w_state_nxt = S_RD0;
`else
        if (m1_awvalid)
          w_state_nxt = S_WR1;
        else if (m1_arvalid)
          w_state_nxt = S_RD1;
        else if (m0_arvalid)
          w_state_nxt = S_RD0;
`endif
      end

      S_RD0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~r_ar_done;
        m0_arready = s_arready & ~r_ar_done;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        s_rready   = m0_rready;
        // A response in the expiry cycle still completes normally.
        if (s_rvalid && m0_rready)
          w_state_nxt = S_IDLE;
        else if (w_expire)
          w_state_nxt = S_TOUT;
      end

      S_RD1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~r_ar_done;
        m1_arready = s_arready & ~r_ar_done;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready)
          w_state_nxt = S_IDLE;
        else if (w_expire)
          w_state_nxt = S_TOUT;
      end

      S_WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~r_aw_done;
        m1_awready = s_awready & ~r_aw_done;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~r_w_done;
        m1_wready  = s_wready & ~r_w_done;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        s_bready   = m1_bready;
        if (s_bvalid && m1_bready)
          w_state_nxt = S_IDLE;
        else if (w_expire)
          w_state_nxt = S_TOUT;
      end

      S_TOUT: begin
        // Slave side stays silent so a late response is never accepted.
        case (r_owner)
          S_RD0: begin
            m0_rvalid = 1'b1;
            m0_rresp  = 2'b10;
            if (m0_rready) w_state_nxt = S_IDLE;
          end
          S_RD1: begin
            m1_rvalid = 1'b1;
            m1_rresp  = 2'b10;
            if (m1_rready) w_state_nxt = S_IDLE;
          end
          S_WR1: begin
            m1_bvalid = 1'b1;
            m1_bresp  = 2'b10;
            if (m1_bready) w_state_nxt = S_IDLE;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= S_IDLE;
      r_ar_done <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cnt     <= '0;
`ifdef ARB_RR_EN
      r_last    <= 1'b1;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        // Everything per-transaction restarts on the way into a grant.
        r_ar_done <= 1'b0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_cnt     <= '0;
        r_owner   <= w_state_nxt;
`ifdef ARB_RR_EN
        if (w_state_nxt != S_IDLE)
          r_last <= (w_state_nxt != S_RD0);
`endif
      end else if (r_state != S_TOUT) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
        if (s_arvalid && s_arready) r_ar_done <= 1'b1;
        if (s_awvalid && s_awready) r_aw_done <= 1'b1;
        if (s_wvalid && s_wready)   r_w_done  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//            (owner, age, accepted-channel flags) predicts every output each
//            cycle; directed scenarios add literal expectations on top of a
//            randomized traffic phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int c_TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [1:0]  m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [1:0]  m1_rresp;
  logic        m1_awvalid, m1_wvalid, m1_awready, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_wstrb;
  logic [1:0]  m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp;

  int errors = 0;
  int checks = 0;

  mem_arbiter #(.TIMEOUT(c_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_wvalid(m1_wvalid),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_awready(m1_awready),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [76:0]  w_dut_m;
  logic [104:0] w_dut_s;
  assign w_dut_m = {m0_arready, m0_rvalid, m0_rdata, m0_rresp,
                    m1_arready, m1_rvalid, m1_rdata, m1_rresp,
                    m1_awready, m1_wready, m1_bvalid, m1_bresp};
  assign w_dut_s = {s_arvalid, s_araddr, s_rready, s_awvalid, s_awaddr,
                    s_wvalid, s_wdata, s_wstrb, s_bready};

  // ---------------------------------------------------------------- model
  // owner: -1 none, 0 m0 read, 1 m1 read, 2 m1 write
  int   own;
  bit   tout;
  int   age;
  bit   ard, awd, wd;
  int   last_m;       // 0 or 1: master served most recently
  bit   mvalid = 1'b0;
  int   win, m1k;
  bit   done;

  logic        e_m0_arready, e_m0_rvalid, e_m1_arready, e_m1_rvalid;
  logic [31:0] e_m0_rdata, e_m1_rdata;
  logic [1:0]  e_m0_rresp, e_m1_rresp, e_m1_bresp;
  logic        e_m1_awready, e_m1_wready, e_m1_bvalid;
  logic        e_s_arvalid, e_s_rready, e_s_awvalid, e_s_wvalid, e_s_bready;
  logic [31:0] e_s_araddr, e_s_awaddr, e_s_wdata;
  logic [3:0]  e_s_wstrb;
  logic [76:0]  e_m;
  logic [104:0] e_s;

  always @(negedge clk) begin
    // expected outputs for the current cycle
    {e_m0_arready, e_m0_rvalid, e_m0_rdata, e_m0_rresp} = '0;
    {e_m1_arready, e_m1_rvalid, e_m1_rdata, e_m1_rresp} = '0;
    {e_m1_awready, e_m1_wready, e_m1_bvalid, e_m1_bresp} = '0;
    {e_s_arvalid, e_s_araddr, e_s_rready, e_s_awvalid, e_s_awaddr} = '0;
    {e_s_wvalid, e_s_wdata, e_s_wstrb, e_s_bready} = '0;
    if (own == 0 && !tout) begin
      e_s_araddr = m0_araddr; e_s_arvalid = m0_arvalid && !ard;
      e_m0_arready = s_arready && !ard;
      e_m0_rvalid = s_rvalid; e_m0_rdata = s_rdata; e_m0_rresp = s_rresp;
      e_s_rready = m0_rready;
    end else if (own == 1 && !tout) begin
      e_s_araddr = m1_araddr; e_s_arvalid = m1_arvalid && !ard;
      e_m1_arready = s_arready && !ard;
      e_m1_rvalid = s_rvalid; e_m1_rdata = s_rdata; e_m1_rresp = s_rresp;
      e_s_rready = m1_rready;
    end else if (own == 2 && !tout) begin
      e_s_awaddr = m1_awaddr; e_s_awvalid = m1_awvalid && !awd;
      e_m1_awready = s_awready && !awd;
      e_s_wdata = m1_wdata; e_s_wstrb = m1_wstrb; e_s_wvalid = m1_wvalid && !wd;
      e_m1_wready = s_wready && !wd;
      e_m1_bvalid = s_bvalid; e_m1_bresp = s_bresp; e_s_bready = m1_bready;
    end else if (tout) begin
      if (own == 0) begin e_m0_rvalid = 1'b1; e_m0_rresp = 2'b10; end
      if (own == 1) begin e_m1_rvalid = 1'b1; e_m1_rresp = 2'b10; end
      if (own == 2) begin e_m1_bvalid = 1'b1; e_m1_bresp = 2'b10; end
    end
    e_m = {e_m0_arready, e_m0_rvalid, e_m0_rdata, e_m0_rresp,
           e_m1_arready, e_m1_rvalid, e_m1_rdata, e_m1_rresp,
           e_m1_awready, e_m1_wready, e_m1_bvalid, e_m1_bresp};
    e_s = {e_s_arvalid, e_s_araddr, e_s_rready, e_s_awvalid, e_s_awaddr,
           e_s_wvalid, e_s_wdata, e_s_wstrb, e_s_bready};

    if (mvalid) begin
      checks++;
      if (w_dut_m !== e_m) begin
        errors++;
        $display("FAIL model_master_side t=%0t owner=%0d: dut=%h model=%h", $time, own, w_dut_m, e_m);
      end
      checks++;
      if (w_dut_s !== e_s) begin
        errors++;
        $display("FAIL model_slave_side t=%0t owner=%0d: dut=%h model=%h", $time, own, w_dut_s, e_s);
      end
    end

    // advance to the next cycle
    if (rst) begin
      own = -1; tout = 0; age = 0; ard = 0; awd = 0; wd = 0; last_m = 1; mvalid = 1;
    end else if (mvalid) begin
      if (own < 0) begin
        m1k = m1_awvalid ? 2 : (m1_arvalid ? 1 : -1);
`ifdef ARB_RR_EN
        if (m0_arvalid && m1k >= 0) win = (last_m == 1) ? 0 : m1k;
        else if (m0_arvalid)        win = 0;
        else                        win = m1k;
`else
        win = (m1k >= 0) ? m1k : (m0_arvalid ? 0 : -1);
`endif
        if (win >= 0) begin
          own = win; age = 0; ard = 0; awd = 0; wd = 0; tout = 0;
          last_m = (win == 0) ? 0 : 1;
        end
      end else if (tout) begin
        if ((own == 0 && m0_rready) || (own == 1 && m1_rready) || (own == 2 && m1_bready)) begin
          own = -1; tout = 0;
        end
      end else begin
        done = (own < 2) ? (s_rvalid && e_s_rready) : (s_bvalid && e_s_bready);
        if (e_s_arvalid && s_arready) ard = 1;
        if (e_s_awvalid && s_awready) awd = 1;
        if (e_s_wvalid && s_wready)   wd  = 1;
        if (done)                          own = -1;
        else if (age == c_TIMEOUT - 1)     tout = 1;
        else                               age++;
      end
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    m0_arvalid = 0; m0_araddr = 0; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
  endtask

  task automatic t_m0_read();
    cyc(); clr();
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_rready = 1; s_arready = 1;
    smp(); chk("m0rd_idle_arready", m0_arready, 0);
    cyc();
    smp(); chk("m0rd_s_arvalid", s_arvalid, 1);
    chk("m0rd_s_araddr", s_araddr, 32'h8000_0000);
    chk("m0rd_arready", m0_arready, 1);
    cyc(); m0_arvalid = 0; m0_araddr = 0; s_rvalid = 1; s_rdata = 32'h0000_0413;
    smp(); chk("m0rd_rvalid", m0_rvalid, 1);
    chk("m0rd_rdata", m0_rdata, 32'h0000_0413);
    chk("m0rd_rresp", m0_rresp, 0);
    chk("m0rd_ar_once", s_arvalid, 0);
    cyc(); s_rvalid = 0; s_rdata = 0; s_arready = 0;
    smp(); chk("m0rd_back_idle", {m0_rvalid, s_rready}, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [31:0] exp_addr;
  bit hs0, hs1, hsaw, hsw;
  int stall;

  initial begin
    rst = 1; clr();
    cyc(); cyc(); cyc(); rst = 0;
    smp(); chk("reset_outputs_zero", {31'd0, |{w_dut_m, w_dut_s}}, 0);

    // single m0 read, 1-cycle slave
    t_m0_read();

    // simultaneous reads from reset, persistent requests
    cyc(); clr(); rst = 1;
    cyc(); rst = 0;
    m0_arvalid = 1; m0_araddr = 32'h100; m1_arvalid = 1; m1_araddr = 32'h200;
    m0_rready = 1; m1_rready = 1; s_arready = 1; s_rvalid = 1;
    for (int g = 0; g < 4; g++) begin
      cyc();
      smp();
`ifdef ARB_RR_EN
      exp_addr = (g % 2 == 0) ? 32'h100 : 32'h200;
`else
      exp_addr = 32'h200;
`endif
      chk($sformatf("tie_grant%0d_addr", g), s_araddr, exp_addr);
      cyc();
    end
    clr();

    // write with aw accepted two cycles before w, m0 read held off
    cyc();
    m1_awvalid = 1; m1_awaddr = 32'h8000_0100; m1_wvalid = 1; m1_wdata = 32'h1234_5678;
    m1_wstrb = 4'b0011; m1_bready = 1; s_awready = 1;
    cyc(); m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_rready = 1;
    smp(); chk("wr_s_awaddr", s_awaddr, 32'h8000_0100);
    chk("wr_aw_hs", {m1_awready, s_awvalid, s_wvalid, m1_wready}, 4'b1110);
    chk("wr_m0_held", m0_arready, 0);
    cyc(); m1_awvalid = 0;
    smp(); chk("wr_aw_once_w_wait", {s_awvalid, m1_wready}, 0);
    cyc(); s_wready = 1;
    smp(); chk("wr_w_hs", m1_wready, 1);
    chk("wr_s_wdata", s_wdata, 32'h1234_5678);
    chk("wr_s_wstrb", s_wstrb, 4'b0011);
    cyc(); m1_wvalid = 0; s_wready = 0; s_bvalid = 1;
    smp(); chk("wr_b_fwd", {m1_bvalid, s_bready, s_wvalid, s_arvalid, m0_arready}, 5'b11000);
    cyc(); s_bvalid = 0; m1_bready = 0;
    smp(); chk("wr_idle_after_b", {s_arvalid, m1_bvalid}, 0);
    cyc(); s_arready = 1; s_rvalid = 1; s_rdata = 32'h55;
    smp(); chk("wr_then_m0_addr", s_araddr, 32'h8000_0000);
    chk("wr_then_m0_rdata", m0_rdata, 32'h55);
    cyc(); clr();

    // write beats read from the same master
    cyc();
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h400; m1_arvalid = 1; m1_araddr = 32'h300;
    m1_bready = 1; m1_rready = 1;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_arready = 1; s_rvalid = 1;
    cyc();
    smp(); chk("wr_first", {s_awvalid, s_arvalid, m1_arready}, 3'b100);
    cyc(); m1_awvalid = 0; m1_wvalid = 0;
    cyc();
    smp(); chk("rd_second_addr", s_araddr, 32'h300);
    cyc(); clr();

    // watchdog on an m0 read whose slave never answers
    cyc();
    m0_arvalid = 1; m0_araddr = 32'h8000_0040; s_arready = 1;
    s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b01;
    cyc();
    smp(); chk("wd_grant_no_rvalid", m0_rvalid, 0);
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 1) m0_arvalid = 0;
      if (k == 17) begin m0_rready = 1; s_rvalid = 1; end
      smp();
      if (k == 15) chk("wd_k15_quiet", m0_rvalid, 0);
      if (k == 16) chk("wd_k16_slverr", {m0_rvalid, m0_rresp, m0_rdata}, {1'b1, 2'b10, 32'h0});
      if (k == 17) chk("wd_held_late_ignored", {m0_rvalid, s_rready}, 2'b10);
    end
    cyc(); s_rvalid = 0; m0_rready = 0;
    smp(); chk("wd_back_idle", m0_rvalid, 0);

    // reset during a write
    cyc(); clr();
    m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h500;
    cyc();
    smp(); chk("rstwr_granted", s_awvalid, 1);
    cyc(); rst = 1;
    cyc(); rst = 0;
    smp(); chk("rstwr_outputs_zero", {31'd0, |{w_dut_m, w_dut_s}}, 0);
    cyc(); s_awready = 1; s_wready = 1; s_bvalid = 1; m1_bready = 1;
    smp(); chk("rstwr_regrant_b", m1_bvalid, 1);
    cyc(); clr();
    t_m0_read();

    // randomized traffic; every cycle is checked against the model
    stall = 0;
    for (int n = 0; n < 3000; n++) begin
      smp();
      hs0  = m0_arvalid && m0_arready;
      hs1  = m1_arvalid && m1_arready;
      hsaw = m1_awvalid && m1_awready;
      hsw  = m1_wvalid && m1_wready;
      cyc();
      rst = ($urandom_range(0, 299) == 0);
      if (hs0) m0_arvalid = 0;
      else if (!m0_arvalid && $urandom_range(0, 3) == 0) begin
        m0_arvalid = 1; m0_araddr = $urandom;
      end
      if (hs1) m1_arvalid = 0;
      else if (!m1_arvalid && $urandom_range(0, 4) == 0) begin
        m1_arvalid = 1; m1_araddr = $urandom;
      end
      if (hsaw) m1_awvalid = 0;
      if (hsw)  m1_wvalid = 0;
      if (!m1_awvalid && !m1_wvalid && $urandom_range(0, 4) == 0) begin
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = $urandom; m1_wdata = $urandom;
        m1_wstrb = 4'($urandom);
      end
      m0_rready = ($urandom_range(0, 3) != 0);
      m1_rready = ($urandom_range(0, 3) != 0);
      m1_bready = ($urandom_range(0, 3) != 0);
      s_rdata = $urandom; s_rresp = 2'($urandom); s_bresp = 2'($urandom);
      if (stall > 0) begin
        stall--;
        s_arready = 0; s_rvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 0;
      end else begin
        if ($urandom_range(0, 39) == 0) stall = 20;
        s_arready = 1'($urandom); s_awready = 1'($urandom); s_wready = 1'($urandom);
        s_rvalid  = ($urandom_range(0, 2) == 0);
        s_bvalid  = ($urandom_range(0, 2) == 0);
      end
    end

    smp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
